// File: rtl/aibcr3_dcc_pkg.sv
// Shared types and helpers for the DCC interpolator code sequencer.
package aibcr3_dcc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2,
        FIN  = 2'd3
    } dcc_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/aibcr3_dcc_therm_enc.sv
// Binary to thermometer encoder: the low 'bin' bits of 'therm' are set.
module aibcr3_dcc_therm_enc
    import aibcr3_dcc_pkg::*;
#(
    parameter int CODE_W = 7,
    localparam int BIN_W = clog2(CODE_W + 1)
) (
    input  logic [BIN_W-1:0]  bin,
    output logic [CODE_W-1:0] therm
);

    always_comb begin
        therm = '0;
        for (int i = 0; i < CODE_W; i++) begin
            therm[i] = (i < int'(bin));
        end
    end

endmodule

// File: rtl/aibcr3_dcc_interp_seq.sv
// Walks the interpolator code one LSB at a time toward a requested target,
// pacing each step with a programmable timer and driving sp/sn thermometer codes.
module aibcr3_dcc_interp_seq
    import aibcr3_dcc_pkg::*;
#(
    parameter int CODE_W     = 7,
    parameter int STEP_DIV   = 4,
    parameter int RESET_CODE = 0,
    localparam int BIN_W     = clog2(CODE_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  tgt_code,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic              freeze,
    output logic [CODE_W-1:0] sp,
    output logic [CODE_W-1:0] sn,
    output logic [BIN_W-1:0]  cur_code,
    output logic              busy,
    output logic              done,
    output logic              clamped
);

    localparam logic [BIN_W-1:0] CODE_MAX   = BIN_W'(CODE_W);
    localparam logic [BIN_W-1:0] CODE_RST   = BIN_W'(RESET_CODE);
    localparam logic [7:0]       TIMER_LOAD = 8'(STEP_DIV - 1);

    dcc_state_e        state;
    dcc_state_e        state_nxt;
    logic [7:0]        timer;
    logic [7:0]        timer_nxt;
    logic [BIN_W-1:0]  tgt;
    logic [BIN_W-1:0]  tgt_nxt;
    logic [BIN_W-1:0]  cur_nxt;
    logic [BIN_W-1:0]  enc_in;
    logic [CODE_W-1:0] therm;
    logic              clamped_nxt;
    logic              xfer;

    assign tgt_ready = (state == IDLE) && !reset;
    assign xfer      = tgt_valid && tgt_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        tgt_nxt     = tgt;
        cur_nxt     = cur_code;
        clamped_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    tgt_nxt     = (tgt_code > CODE_MAX) ? CODE_MAX : tgt_code;
                    clamped_nxt = (tgt_code > CODE_MAX);
                    timer_nxt   = TIMER_LOAD;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                if (!freeze) begin
                    if (timer == 8'd0) begin
                        state_nxt = (cur_code == tgt) ? FIN : STEP;
                    end else begin
                        timer_nxt = timer - 8'd1;
                    end
                end
            end
            STEP: begin
                // Exactly one LSB per visit, never past either rail.
                if (!freeze) begin
                    if ((cur_code < tgt) && (cur_code < CODE_MAX)) begin
                        cur_nxt = cur_code + BIN_W'(1);
                    end else if ((cur_code > tgt) && (cur_code != '0)) begin
                        cur_nxt = cur_code - BIN_W'(1);
                    end
                    state_nxt = (cur_nxt == tgt) ? FIN : WAIT;
                    timer_nxt = TIMER_LOAD;
                end
            end
            FIN: begin
                state_nxt = IDLE;
                timer_nxt = 8'd0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One encoder serves both reset and normal updates so sp/sn track cur_code exactly.
    assign enc_in = reset ? CODE_RST : cur_nxt;

    aibcr3_dcc_therm_enc #(
        .CODE_W (CODE_W)
    ) u_therm_enc (
        .bin   (enc_in),
        .therm (therm)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= 8'd0;
            tgt      <= CODE_RST;
            cur_code <= CODE_RST;
            clamped  <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            tgt      <= tgt_nxt;
            cur_code <= cur_nxt;
            clamped  <= clamped_nxt;
        end
        sp <= therm;
        sn <= ~therm;
    end

endmodule
